// File: rtl/fifo_stream_reader.sv
// Read-side drain controller: issues FIFO reads, captures data one cycle later into a 2-entry buffer,
// presents it as a valid/ready stream (rd->m_valid 2 cycles, 1 word/cycle); optional counter under FIFO_READER_STATS_EN.
module fifo_stream_reader #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             idle,
    output logic [CNT_W-1:0] words_out
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             inflight_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ;
    logic [2:0]       commit;
    logic             pop;

    // State register and buffer datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd && !fifo_empty;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Next state; a returning word always lands in a free slot because reads are
    // only issued while committed occupancy stays below two.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (inflight_q) begin
                    state_d = S_ONE;
                    head_d  = fifo_data;
                end
            end
            S_ONE: begin
                if (inflight_q && !pop) begin
                    state_d = S_TWO;
                    tail_d  = fifo_data;
                end else if (inflight_q && pop) begin
                    head_d  = fifo_data;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_d = S_ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Outputs.
    always_comb begin
        occ     = 2'd0;
        m_valid = 1'b0;
        idle    = 1'b0;
        case (state_q)
            S_ONE:   occ = 2'd1;
            S_TWO:   occ = 2'd2;
            default: occ = 2'd0;
        endcase
        m_valid = (occ != 2'd0);
        idle    = (occ == 2'd0) && !inflight_q;
    end

    assign m_data  = head_q;
    assign pop     = m_valid && m_ready;
    assign commit  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd = reset_n && drain_en && !fifo_empty && (commit < 3'd2);

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pop};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign words_out = cnt_q;
`else
    assign words_out = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue models the byte FIFO, a second queue holds expected stream order.
module tb_fifo_stream_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        drain_en = 1'b1;
    logic        fifo_empty = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        idle;
    logic [15:0] words_out;

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .drain_en   (drain_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .idle       (idle),
        .words_out  (words_out)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  fq[$];
    logic [7:0]  sb[$];
    int          out_cnt = 0;
    bit          last_acc = 0;
    bit          rd_now = 0;
    bit          vld_now = 0;
    int          n_rd = 0;
    int          n_pop = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = 8'h00;
    logic [15:0] pops_model = 16'd0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops and protocol checks, sampled mid-cycle.
    always @(negedge clock) begin : monitor
        bit         acc, pop;
        logic [7:0] exp_w;
        logic [15:0] exp_cnt;
        if (reset_n) begin
            acc = fifo_rd && !fifo_empty;
            pop = m_valid && m_ready;
            if (fifo_rd) begin
                chk("rd_when_empty", !fifo_empty, longint'(fifo_empty), 0);
                chk("rd_overfill", (out_cnt - int'(pop)) < 2, out_cnt - int'(pop), 1);
            end
            chk("idle", idle == (out_cnt == 0), longint'(idle), longint'(out_cnt == 0));
            if (prev_stall) begin
                chk("stall_valid", m_valid == 1'b1, longint'(m_valid), 1);
                chk("stall_data", m_data == prev_data, longint'(m_data), longint'(prev_data));
            end
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 1'b0, longint'(m_data), 0);
                end else begin
                    exp_w = sb.pop_front();
                    chk("data_order", m_data == exp_w, longint'(m_data), longint'(exp_w));
                end
            end
`ifdef FIFO_READER_STATS_EN
            exp_cnt = pops_model;
`else
            exp_cnt = 16'd0;
`endif
            chk("words_out", words_out == exp_cnt, longint'(words_out), longint'(exp_cnt));
            out_cnt    = out_cnt + int'(acc) - int'(pop);
            pops_model = pops_model + 16'(pop);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            last_acc   = acc;
            rd_now     = fifo_rd;
            vld_now    = m_valid;
            n_rd       = n_rd + int'(acc);
            n_pop      = n_pop + int'(pop);
        end else begin
            last_acc   = 0;
            prev_stall = 0;
            rd_now     = 0;
            vld_now    = 0;
        end
    end

    // One clock: behavioural FIFO updates its registered data_out after an accepted read.
    task automatic step();
        @(posedge clock);
        #1;
        if (last_acc) begin
            if (fq.size() > 0) fifo_data = fq.pop_front();
            else chk("fifo_underflow", 1'b0, 0, 1);
        end else begin
            fifo_data = 8'($urandom);
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push_word(input logic [7:0] w);
        fq.push_back(w);
        sb.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 0;
        drain_en = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < bound && !done; i++) begin
            step();
            done = (sb.size() == 0) && (fq.size() == 0) && (out_cnt == 0);
        end
        chk("drain_timeout", done, longint'(sb.size()), 0);
        chk("idle_end", idle == 1'b1, longint'(idle), 1);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        fq.delete();
        sb.delete();
        out_cnt    = 0;
        pops_model = 16'd0;
        last_acc   = 0;
        prev_stall = 0;
        fifo_empty = 1'b1;
        #1;
        chk("rst_m_valid", m_valid == 1'b0, longint'(m_valid), 0);
        chk("rst_idle", idle == 1'b1, longint'(idle), 1);
        chk("rst_fifo_rd", fifo_rd == 1'b0, longint'(fifo_rd), 0);
        chk("rst_m_data", m_data == 8'h00, longint'(m_data), 0);
        chk("rst_words_out", words_out == 16'd0, longint'(words_out), 0);
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    initial begin
        int         t_rd, t_vld, last_v, nv, base;
        bit         seen;
        logic [7:0] b3 [4];

        // Reset state, with drain_en=1 and a non-empty FIFO to show fifo_rd is gated.
        #12;
        chk("init_fifo_rd", fifo_rd == 1'b0, longint'(fifo_rd), 0);
        chk("init_m_valid", m_valid == 1'b0, longint'(m_valid), 0);
        chk("init_idle", idle == 1'b1, longint'(idle), 1);
        chk("init_m_data", m_data == 8'h00, longint'(m_data), 0);
        chk("init_words_out", words_out == 16'd0, longint'(words_out), 0);
        fifo_empty = 1'b1;
        step();
        reset_n = 1'b1;

        // Three words, latency and back-to-back delivery.
        drain_en = 1'b1;
        m_ready  = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        t_rd = -1; t_vld = -1; last_v = -1; nv = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (rd_now && t_rd < 0) t_rd = i;
            if (vld_now) begin
                if (t_vld < 0) t_vld = i;
                last_v = i;
                nv++;
            end
        end
        chk("latency", (t_rd >= 0) && (t_vld - t_rd == 2), t_vld - t_rd, 2);
        chk("burst_len", nv == 3, nv, 3);
        chk("burst_contig", last_v - t_vld == 2, last_v - t_vld, 2);
        chk("burst_idle", idle == 1'b1, longint'(idle), 1);
        chk("burst_sb", sb.size() == 0, longint'(sb.size()), 0);

        // 32 words with m_ready pattern 1,0,0,1.
        for (int i = 0; i < 32; i++) push_word(8'(i));
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            m_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
            seen = (sb.size() == 0) && (out_cnt == 0);
        end
        chk("pattern_done", seen, longint'(sb.size()), 0);

        // Stalled downstream: exactly two reads issued.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        base = n_rd;
        repeat (10) step();
        chk("stall_reads", n_rd - base == 2, n_rd - base, 2);
        chk("stall_no_rd", rd_now == 1'b0, longint'(rd_now), 0);
        chk("stall_occ", out_cnt == 2, out_cnt, 2);
        chk("stall_vld", vld_now == 1'b1, longint'(vld_now), 1);
        m_ready = 1'b1;
        base = n_pop;
        repeat (5) step();
        chk("release_rate", n_pop - base == 5, n_pop - base, 5);
        drain(20);

        // drain_en dropped right after the read of 0xA5.
        b3[0] = 8'hA5; b3[1] = 8'h01; b3[2] = 8'h02; b3[3] = 8'h03;
        for (int i = 0; i < 4; i++) push_word(b3[i]);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = rd_now;
        end
        chk("a5_read_seen", seen, longint'(seen), 1);
        drain_en = 1'b0;
        base = n_rd;
        repeat (8) step();
        chk("no_more_rd", n_rd == base, n_rd - base, 0);
        chk("fifo_retained", fq.size() == 3, longint'(fq.size()), 3);
        chk("a5_delivered", sb.size() == 3, longint'(sb.size()), 3);
        drain(20);

        // Reset mid-stream with a full buffer.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h80 + 8'(i));
        repeat (6) step();
        chk("pre_rst_occ", out_cnt == 2, out_cnt, 2);
        do_reset();
        push_word(8'h5A);
        push_word(8'h5B);
        push_word(8'h5C);
        drain(20);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            m_ready  = ($urandom_range(0, 3) != 0);
            drain_en = ($urandom_range(0, 9) != 0);
            if (fq.size() < 32 && $urandom_range(0, 2) != 0) push_word(8'($urandom));
            step();
        end
        drain(200);

        // Delivered-word counter over 40 words.
        do_reset();
        for (int i = 0; i < 20; i++) push_word(8'($urandom));
        drain(60);
        for (int i = 0; i < 20; i++) push_word(8'($urandom));
        drain(60);
`ifdef FIFO_READER_STATS_EN
        chk("words_out_40", words_out == 16'd40, longint'(words_out), 40);
`else
        chk("words_out_off", words_out == 16'd0, longint'(words_out), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
